// File: rtl/control_unit.sv
// Multi-cycle accumulator CPU controller: START/FETCH/DECODE then one execute state per opcode.
// Optional INPUT_HANDSHAKE_EN makes INPUT wait for the Enter strobe before loading A.
module control_unit (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] IR,
  input  logic       Aeq0,
  input  logic       Apos,
  input  logic       Enter,
  output logic       IRload,
  output logic       PCload,
  output logic       JMPmux,
  output logic       Meminst,
  output logic       MemWr,
  output logic       Aload,
  output logic       Sub,
  output logic [1:0] Asel,
  output logic       Halt
);

  typedef enum logic [3:0] {
    S_START, S_FETCH, S_DECODE, S_LOAD, S_STORE, S_ADD,
    S_SUB, S_INPUT, S_JZ, S_JPOS, S_HALT
  } state_t;

  state_t state, next_state;

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_START;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_START:  next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (IR)
          3'b000:  next_state = S_LOAD;
          3'b001:  next_state = S_STORE;
          3'b010:  next_state = S_ADD;
          3'b011:  next_state = S_SUB;
          3'b100:  next_state = S_INPUT;
          3'b101:  next_state = S_JZ;
          3'b110:  next_state = S_JPOS;
          default: next_state = S_HALT;
        endcase
      end
`ifdef INPUT_HANDSHAKE_EN
      S_INPUT:  next_state = Enter ? S_START : S_INPUT;
`else
      S_INPUT:  next_state = S_START;
`endif
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_START;
    endcase
  end

  // Reset gates every output so no write or PC load can leak mid-instruction.
  always_comb begin
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    Aload   = 1'b0;
    Sub     = 1'b0;
    Asel    = 2'b00;
    Halt    = 1'b0;
    if (!Reset) begin
      case (state)
        S_FETCH: begin
          IRload = 1'b1;
          PCload = 1'b1;
        end
        S_DECODE: Meminst = 1'b1;
        S_LOAD: begin
          Meminst = 1'b1;
          Asel    = 2'b10;
          Aload   = 1'b1;
        end
        S_STORE: begin
          Meminst = 1'b1;
          MemWr   = 1'b1;
        end
        S_ADD: begin
          Meminst = 1'b1;
          Aload   = 1'b1;
        end
        S_SUB: begin
          Meminst = 1'b1;
          Aload   = 1'b1;
          Sub     = 1'b1;
        end
        S_INPUT: begin
          Asel = 2'b01;
`ifdef INPUT_HANDSHAKE_EN
          Aload = Enter;
`else
          Aload = 1'b1;
`endif
        end
        S_JZ: begin
          JMPmux = 1'b1;
          PCload = Aeq0;
        end
        S_JPOS: begin
          JMPmux = 1'b1;
          PCload = Apos;
        end
        S_HALT:  Halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed + random check of control_unit against an instruction-phase model
// (phase within instruction, captured opcode, halted flag).
module tb_control_unit;

  logic       Clock = 1'b0;
  logic       Reset, Aeq0, Apos, Enter;
  logic [2:0] IR;
  logic       IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;

  int errors = 0;
  int checks = 0;

  // Model: phase 0..3 = START, FETCH, DECODE, execute.
  int         m_phase = 0;
  logic [2:0] m_op = 3'b000;
  bit         m_halted = 1'b0;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .Enter(Enter),
    .IRload(IRload), .PCload(PCload), .JMPmux(JMPmux), .Meminst(Meminst),
    .MemWr(MemWr), .Aload(Aload), .Sub(Sub), .Asel(Asel), .Halt(Halt)
  );

  always #5 Clock = ~Clock;

`ifdef INPUT_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  // Vector order: IRload PCload JMPmux Meminst MemWr Aload Sub Asel[1:0] Halt
  function automatic logic [9:0] model_out();
    logic [9:0] v;
    v = '0;
    if (Reset) return v;
    if (m_halted) return 10'b00000_0000_1;
    case (m_phase)
      1: v = 10'b11000_0000_0;
      2: v = 10'b00010_0000_0;
      3: case (m_op)
           3'd0: v = 10'b00010_1010_0;            // A <- mem
           3'd1: v = 10'b00011_0000_0;            // mem <- A
           3'd2: v = 10'b00010_1000_0;            // A + M
           3'd3: v = 10'b00010_1100_0;            // A - M
           3'd4: v = {5'b00000, (HS ? Enter : 1'b1), 1'b0, 2'b01, 1'b0};
           3'd5: v = {1'b0, Aeq0, 1'b1, 7'b0};
           3'd6: v = {1'b0, Apos, 1'b1, 7'b0};
           default: v = '0;
         endcase
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    if (Reset) begin
      m_phase = 0; m_halted = 1'b0;
    end else if (!m_halted) begin
      case (m_phase)
        0: m_phase = 1;
        1: m_phase = 2;
        2: begin
          m_op = IR;
          if (IR == 3'd7) m_halted = 1'b1;
          else m_phase = 3;
        end
        default: if (!(m_op == 3'd4 && HS && !Enter)) m_phase = 0;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s phase=%0d op=%0d observed=%b expected=%b", tag, m_phase, m_op, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic r, input logic [2:0] ir,
                     input logic z, input logic p, input logic e);
    logic [9:0] obs;
    @(negedge Clock);
    Reset = r; IR = ir; Aeq0 = z; Apos = p; Enter = e;
    #1;
    obs = {IRload, PCload, JMPmux, Meminst, MemWr, Aload, Sub, Asel, Halt};
    chk(tag, obs, model_out());
    checks++;
    assert (!(MemWr && PCload) && Asel !== 2'b11) else begin
      errors++;
      $error("FAIL %s_invariant observed MemWr=%b PCload=%b Asel=%b required no MemWr+PCload and Asel!=11",
             tag, MemWr, PCload, Asel);
    end
    @(posedge Clock);
    model_step();
  endtask

  // One full instruction from START with constant inputs.
  task automatic instr(input string tag, input logic [2:0] op, input logic z, input logic p);
    for (int i = 0; i < 4; i++) cyc(tag, 1'b0, op, z, p, 1'b1);
  endtask

  initial begin
    Reset = 1'b1; IR = '0; Aeq0 = 0; Apos = 0; Enter = 0;
    cyc("reset0", 1'b1, 3'd2, 1'b1, 1'b1, 1'b1);
    cyc("reset1", 1'b1, 3'd2, 1'b1, 1'b1, 1'b1);
    instr("add", 3'd2, 1'b0, 1'b0);
    instr("sub", 3'd3, 1'b0, 1'b0);
    instr("jz_taken", 3'd5, 1'b1, 1'b0);
    instr("jz_not", 3'd5, 1'b0, 1'b1);
    instr("jpos_taken", 3'd6, 1'b0, 1'b1);
    instr("jpos_not", 3'd6, 1'b1, 1'b0);
    instr("load", 3'd0, 1'b0, 1'b0);
    instr("store", 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("store_pre", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    cyc("store_reset", 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    cyc("after_store_reset", 1'b0, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cyc("input_pre", 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc("input_wait", 1'b0, 3'd4, 1'b0, 1'b0, 1'b0);
    cyc("input_enter", 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
    cyc("input_done", 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc("halt_pre", 1'b0, 3'd7, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cyc("halt_hold", 1'b0, $urandom_range(7, 0), 1'b1, 1'b1, 1'b1);
    cyc("halt_reset", 1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
    cyc("halt_exit", 1'b0, 3'd7, 1'b0, 1'b0, 1'b0);

    // Random traffic; halts are kept rare so the run mostly exercises instructions.
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic [2:0] op;
      r  = m_halted ? ($urandom_range(3, 0) == 0) : ($urandom_range(49, 0) == 0);
      op = $urandom_range(6, 0);
      if ($urandom_range(29, 0) == 0) op = 3'd7;
      cyc("random", r, op, 1'($urandom), 1'($urandom), ($urandom_range(2, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; the opcode map and state encoding are fixed.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 IR  input  3  opcode field (instruction bits 7:5) from the datapath instruction register.
REQ-005 Aeq0  input  1  high when accumulator A equals 0.
REQ-006 Apos  input  1  high when A[7] is 0.
REQ-007 Enter  input  1  operator-ready strobe for INPUT; used only when INPUT_HANDSHAKE_EN is defined.
REQ-008 IRload  output  1  load the instruction register from memory output.
REQ-009 PCload  output  1  load the PC.
REQ-010 JMPmux  output  1  PC source: 0 = PC+1, 1 = IR[4:0].
REQ-011 Meminst  output  1  memory address source: 0 = PC, 1 = IR[4:0].
REQ-012 MemWr  output  1  memory write strobe; write data is A.
REQ-013 Aload  output  1  load A.
REQ-014 Sub  output  1  ALU operation: 0 = A+M, 1 = A-M.
REQ-015 Asel  output  2  A source: 00 = ALU, 01 = data_in, 10 = memory, 11 = unused (never driven).
REQ-016 Halt  output  1  high while in HALT.

Function
REQ-017 States SHALL be START, FETCH, DECODE, LOAD, STORE, ADD, SUB, INPUT, JZ, JPOS and HALT, held in one state register.
REQ-018 Outputs not named for a state SHALL be 0 in that state.
REQ-019 START: all outputs 0; next state FETCH.
REQ-020 FETCH: IRload=1, PCload=1, JMPmux=0, Meminst=0; next state DECODE.
REQ-021 DECODE: Meminst=1. Next state by IR: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 INPUT, 101 JZ, 110 JPOS, 111 HALT.
REQ-022 LOAD: Meminst=1, Asel=10, Aload=1; next state START.
REQ-023 STORE: Meminst=1, MemWr=1; next state START.
REQ-024 ADD: Meminst=1, Asel=00, Sub=0, Aload=1; next state START.
REQ-025 SUB: same as ADD but with Sub=1; next state START.
REQ-026 INPUT: Asel=01, Aload=1; next state START (but see REQ-035).
REQ-027 JZ: JMPmux=1; PCload=Aeq0, sampled combinationally in that cycle; next state START.
REQ-028 JPOS: JMPmux=1; PCload=Apos; next state START.
REQ-029 HALT: Halt=1 and all other outputs 0; the block SHALL stay in HALT until Reset.
REQ-030 Instruction latency SHALL be 4 cycles (START, FETCH, DECODE, execute), except INPUT waiting and HALT.
REQ-031 MemWr and PCload SHALL never both be 1 in the same cycle.
REQ-032 Asel=11 SHALL never be output.

Reset
REQ-033 With Reset high at a rising edge, from any state including mid-instruction and HALT, the next state SHALL be START.
REQ-034 In any cycle where Reset is high, every output SHALL be forced to 0 combinationally, with no MemWr or PCload pulse.

Configuration
REQ-035 INPUT_HANDSHAKE_EN defined: INPUT SHALL assert Aload only when Enter=1 and SHALL stay in INPUT with Aload=0 while Enter=0. Asel=01 SHALL be held throughout.
REQ-036 INPUT_HANDSHAKE_EN undefined: Enter SHALL be ignored and INPUT SHALL complete in one cycle as in REQ-026.

Verification
REQ-037 Reset for 2 cycles, then release -> state sequence START, FETCH; IRload=PCload=1 in the FETCH cycle; all outputs 0 during reset.
REQ-038 IR=010 at DECODE -> ADD cycle: Meminst=1, Asel=00, Sub=0, Aload=1; START 4 cycles after the prior START. Repeat with IR=011 -> Sub=1.
REQ-039 IR=101 with Aeq0=1 -> JZ cycle has JMPmux=1, PCload=1. With Aeq0=0 -> PCload=0. Same pair of checks for IR=110 with Apos.
REQ-040 IR=001 -> exactly one cycle of MemWr=1 with Meminst=1. Reset asserted during STORE -> MemWr=0 in that cycle, START next.
REQ-041 IR=111 -> Halt=1 held for 20 cycles with all other outputs 0; then Reset -> START, Halt=0.
REQ-042 INPUT_HANDSHAKE_EN defined, IR=100, Enter low for 5 cycles then high -> Aload=0 for 5 cycles, Aload=1 for one cycle, then START. Macro undefined -> Aload=1 immediately.
